lz77_decoder: RTL and testbench

Receives the LZ77 code stream (offset, match_len, char_nxt) produced by the team's LZ77 encoder and rebuilds the original 4-bit symbol string, one symbol per cycle. It keeps an 11-entry search buffer matching the encoder's window and a 5-entry look-ahead, so the maximum match length is 4. It sits downstream of the encoder and asserts finish when it decodes the end marker 8'h24 ('$').

---
 rtl/lz77_pkg.sv | 16 +
 rtl/lz77_window.sv | 21 ++
 rtl/lz77_decoder.sv | 101 ++++++++++
 tb/tb_lz77_decoder.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/lz77_pkg.sv
// lz77_pkg: parameters, FSM states and code-triple type shared by the LZ77 encoder and decoder.
package lz77_pkg;
  localparam int SB_LEN = 11;
  localparam int LA_LEN = 5;
  localparam int SYM_W = 4;
  localparam int OFF_W = 4;
  localparam int LEN_W = 3;
  localparam int CNT_W = 12;
  localparam logic [7:0] END_CHAR = 8'h24;
  typedef enum logic [1:0] {IDLE, COPY, LIT, DONE} state_e;
  typedef struct packed {
    logic [OFF_W-1:0] offset;
    logic [LEN_W-1:0] match_len;
    logic [7:0]       char_nxt;
  } code_t;
endpackage

// File: rtl/lz77_window.sv
// lz77_window: search buffer shift register, sb_q[0] newest; out-of-range reads return 0.
module lz77_window
  import lz77_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_i,
  input  logic [SYM_W-1:0] din_i,
  input  logic [OFF_W-1:0] idx_i,
  output logic [SYM_W-1:0] dout_o
);
  logic [SYM_W-1:0] sb_q [SB_LEN];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sb_q <= '{default: '0};
    else if (shift_i) begin
      sb_q[0] <= din_i;
      for (int i = 1; i < SB_LEN; i++) sb_q[i] <= sb_q[i-1];
    end
  end
  assign dout_o = (idx_i < OFF_W'(SB_LEN)) ? sb_q[idx_i] : '0;
endmodule

// File: rtl/lz77_decoder.sv
// lz77_decoder: rebuilds the symbol stream from (offset, match_len, char_nxt) codes, one symbol per cycle.
// Optional protocol checking on err is built when LZ77_DEC_CHECK_EN is defined.
module lz77_decoder
  import lz77_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             code_valid,
  output logic             code_ready,
  input  logic [OFF_W-1:0] offset,
  input  logic [LEN_W-1:0] match_len,
  input  logic [7:0]       char_nxt,
  output logic             char_valid,
  output logic [7:0]       char_out,
  output logic             encode,
  output logic             finish,
  output logic             err
);
  state_e state_q, state_d;
  code_t code_q, code_d;
  logic char_valid_q, char_valid_d, finish_q, finish_d, shift;
  logic [7:0] char_out_q, char_out_d;
  logic [SYM_W-1:0] din, dout;
  logic [LEN_W-1:0] len_c;
  lz77_window u_win (.clk(clk), .reset(reset), .shift_i(shift), .din_i(din), .idx_i(code_q.offset), .dout_o(dout));
  assign len_c = (match_len > LEN_W'(LA_LEN-1)) ? LEN_W'(LA_LEN-1) : match_len;
  // code_q.match_len doubles as the remaining-copy counter
  always_comb begin
    state_d = state_q;
    code_d = code_q;
    char_valid_d = 1'b0;
    char_out_d = char_out_q;
    finish_d = finish_q;
    shift = 1'b0;
    din = dout;
    case (state_q)
      IDLE: if (code_valid) begin
        code_d = '{offset, len_c, char_nxt};
        state_d = (len_c == '0) ? LIT : COPY;
      end
      COPY: begin
        shift = 1'b1;
        char_valid_d = 1'b1;
        char_out_d = {4'h0, dout};
        code_d.match_len = code_q.match_len - 1'b1;
        state_d = (code_q.match_len == LEN_W'(1)) ? LIT : COPY;
      end
      LIT: if (code_q.char_nxt == END_CHAR) begin
        finish_d = 1'b1;
        state_d = DONE;
      end else begin
        shift = 1'b1;
        din = code_q.char_nxt[3:0];
        char_valid_d = 1'b1;
        char_out_d = {4'h0, code_q.char_nxt[3:0]};
        state_d = IDLE;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      code_q <= '0;
      char_valid_q <= 1'b0;
      char_out_q <= '0;
      finish_q <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q <= code_d;
      char_valid_q <= char_valid_d;
      char_out_q <= char_out_d;
      finish_q <= finish_d;
    end
  end
  assign code_ready = (state_q == IDLE);
  assign char_valid = char_valid_q;
  assign char_out = char_out_q;
  assign finish = finish_q;
  assign encode = 1'b0;
`ifdef LZ77_DEC_CHECK_EN
  logic [CNT_W-1:0] cnt_q;
  logic err_q, bad;
  assign bad = code_ready && code_valid &&
               (offset >= OFF_W'(SB_LEN) || match_len > LEN_W'(LA_LEN-1) ||
                (match_len != '0 && CNT_W'(offset) >= cnt_q) ||
                (char_nxt == END_CHAR && cnt_q != CNT_W'(2048)));
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (char_valid_d && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
      if (bad) err_q <= 1'b1;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_lz77_decoder.sv
// tb_lz77_decoder: directed checks of the LZ77 decoder plus a 2048-symbol encode/decode round trip.
module tb_lz77_decoder;
  import lz77_pkg::*;
  logic clk = 0, reset = 0, code_valid = 0;
  logic [3:0] offset = 0;
  logic [2:0] match_len = 0;
  logic [7:0] char_nxt = 0;
  logic code_ready, char_valid, encode, finish, err;
  logic [7:0] char_out;
  int nchk = 0, nerr = 0;
  logic [7:0] rx[$];
  logic [3:0] src[2048];
  code_t codes[$];
`ifdef LZ77_DEC_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  lz77_decoder dut (.clk(clk), .reset(reset), .code_valid(code_valid), .code_ready(code_ready),
                    .offset(offset), .match_len(match_len), .char_nxt(char_nxt), .char_valid(char_valid),
                    .char_out(char_out), .encode(encode), .finish(finish), .err(err));

  always #5 clk = ~clk;
  always @(negedge clk) if (reset && char_valid) rx.push_back(char_out);

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 0;
    repeat (2) @(negedge clk);
    reset = 1;
  endtask

  task automatic send(input int o, input int l, input logic [7:0] c);
    int n = 0;
    @(negedge clk);
    while (!code_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      nchk++;
      nerr++;
      $error("FAIL ready_timeout: got 0 want 1");
    end
    offset = 4'(o);
    match_len = 3'(l);
    char_nxt = c;
    code_valid = 1;
    @(posedge clk);
    #1 code_valid = 0;
  endtask

  task automatic expect_sym(input string tag, input logic [7:0] v);
    @(negedge clk);
    chk({tag, "_valid"}, 32'(char_valid), 1);
    chk({tag, "_data"}, 32'(char_out), 32'(v));
  endtask

  initial begin
    int p, l, bo, bl, mism;
    do_reset();
    @(negedge clk);
    chk("rst_valid", 32'(char_valid), 0);
    chk("rst_out", 32'(char_out), 0);
    chk("rst_finish", 32'(finish), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_ready", 32'(code_ready), 1);
    chk("encode", 32'(encode), 0);
    // single literal
    send(0, 0, 8'h03);
    @(negedge clk);
    chk("t1_bubble_valid", 32'(char_valid), 0);
    chk("t1_bubble_ready", 32'(code_ready), 0);
    expect_sym("t1_sym", 8'h03);
    chk("t1_ready_with_sym", 32'(code_ready), 1);
    @(negedge clk);
    chk("t1_idle_valid", 32'(char_valid), 0);
    chk("t1_hold_out", 32'(char_out), 8'h03);
    // overlapping copy
    send(0, 2, 8'h05);
    @(negedge clk);
    chk("t2_bubble_valid", 32'(char_valid), 0);
    expect_sym("t2_s0", 8'h03);
    chk("t2_ready_copy", 32'(code_ready), 0);
    expect_sym("t2_s1", 8'h03);
    expect_sym("t2_s2", 8'h05);
    chk("t2_ready_end", 32'(code_ready), 1);
    chk("t2_sb0", 32'(dut.u_win.sb_q[0]), 5);
    chk("t2_sb1", 32'(dut.u_win.sb_q[1]), 3);
    chk("t2_sb2", 32'(dut.u_win.sb_q[2]), 3);
    // far offset into zeroed window, then clamped length
    do_reset();
    send(10, 3, 8'h07);
    @(negedge clk);
    expect_sym("t3_s0", 8'h00);
    expect_sym("t3_s1", 8'h00);
    expect_sym("t3_s2", 8'h00);
    expect_sym("t3_s3", 8'h07);
    chk("t3_err", 32'(err), 32'(EXP_ERR));
    send(0, 6, 8'h08);
    @(negedge clk);
    expect_sym("t3c_s0", 8'h07);
    expect_sym("t3c_s1", 8'h07);
    expect_sym("t3c_s2", 8'h07);
    expect_sym("t3c_s3", 8'h07);
    expect_sym("t3c_s4", 8'h08);
    @(negedge clk);
    chk("t3c_no_extra", 32'(char_valid), 0);
    // end marker
    send(0, 0, 8'h24);
    @(negedge clk);
    chk("t4_bubble_valid", 32'(char_valid), 0);
    @(negedge clk);
    chk("t4_no_sym", 32'(char_valid), 0);
    chk("t4_finish", 32'(finish), 1);
    chk("t4_sb0_unshifted", 32'(dut.u_win.sb_q[0]), 8);
    offset = 0;
    match_len = 0;
    char_nxt = 8'h03;
    code_valid = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t4_done_valid", 32'(char_valid), 0);
      chk("t4_done_ready", 32'(code_ready), 0);
      chk("t4_done_finish", 32'(finish), 1);
    end
    code_valid = 0;
    // reset in the middle of a copy
    do_reset();
    chk("t5_finish_cleared", 32'(finish), 0);
    send(0, 0, 8'h0A);
    send(0, 0, 8'h0B);
    send(1, 4, 8'h09);
    @(negedge clk);
    expect_sym("t5_s0", 8'h0A);
    #1 reset = 0;
    #1 chk("t5_valid_drop", 32'(char_valid), 0);
    #2 reset = 1;
    @(negedge clk);
    chk("t5_ready", 32'(code_ready), 1);
    chk("t5_valid", 32'(char_valid), 0);
    chk("t5_finish", 32'(finish), 0);
    for (int i = 0; i < SB_LEN; i++) chk($sformatf("t5_sb%0d", i), 32'(dut.u_win.sb_q[i]), 0);
    @(negedge clk);
    chk("t5_no_partial", 32'(char_valid), 0);
    // round trip of a 2048-symbol string through a greedy bench-side encoder
    do_reset();
    for (int i = 0; i < 2048; i++) src[i] = 4'($urandom_range(0, 3));
    p = 0;
    while (p < 2048) begin
      bo = 0;
      bl = 0;
      for (int o = 0; o < SB_LEN && o < p; o++) begin
        l = 0;
        while (l < LA_LEN - 1 && p + l < 2047 && src[p+l] == src[p-1-o+l]) l++;
        if (l > bl) begin
          bl = l;
          bo = o;
        end
      end
      codes.push_back('{4'(bo), 3'(bl), {4'h0, src[p+bl]}});
      p += bl + 1;
    end
    rx.delete();
    foreach (codes[i]) send(int'(codes[i].offset), int'(codes[i].match_len), codes[i].char_nxt);
    send(0, 0, END_CHAR);
    repeat (3) @(negedge clk);
    chk("t6_finish", 32'(finish), 1);
    chk("t6_err", 32'(err), 0);
    chk("t6_count", rx.size(), 2048);
    mism = 0;
    for (int i = 0; i < 2048 && i < rx.size(); i++) if (rx[i] !== {4'h0, src[i]}) mism++;
    chk("t6_stream_mismatches", 32'(mism), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
